// File: rtl/minmax_interval_sequencer.sv
// Sequencer that streams N samples from memory to a min/max engine interval by interval
// and writes one result per interval. Optional WAIT_RES timeout: define MINMAX_SEQ_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start
// CHECK    | validate latched interval length
// FETCH    | issue memory read for current sample
// CAPTURE  | register read data toward the engine
// SEND     | present sample until the engine accepts it
// WAIT_RES | wait for the engine's per-interval result
// WRITE    | write result to the result buffer
// FIN      | pulse done, back to IDLE
module minmax_interval_sequencer #(
    parameter int N             = 100,
    parameter int MAX_INTERVALS = 10,
    parameter int AW            = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          interval_len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 mem_rd,
    output logic [AW-1:0]        mem_addr,
    input  logic signed [31:0]   mem_rdata,
    output logic                 eng_valid,
    output logic                 eng_first,
    output logic                 eng_last,
    output logic signed [31:0]   eng_data,
    input  logic                 eng_ready,
    input  logic                 eng_res_valid,
    input  logic signed [31:0]   eng_res_max,
    input  logic signed [31:0]   eng_res_min,
    output logic                 res_we,
    output logic [AW-1:0]        res_addr,
    output logic signed [31:0]   res_max,
    output logic signed [31:0]   res_min
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        CAPTURE,
        SEND,
        WAIT_RES,
        WRITE,
        FIN
    } state_t;

    localparam logic [AW-1:0] LP_LAST_SMP = AW'(N - 1);
    localparam logic [47:0]   LP_N48      = 48'(N);
    localparam logic [47:0]   LP_MAX48    = 48'(MAX_INTERVALS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_len;
    logic [15:0]          r_in_cnt;
    logic [AW-1:0]        r_sample_cnt;
    logic [AW-1:0]        r_int_cnt;
    logic                 r_error;
    logic signed [31:0]   r_eng_data;
    logic signed [31:0]   r_res_max;
    logic signed [31:0]   r_res_min;
    logic [47:0]          w_span;
    logic                 w_cfg_bad;
    logic                 w_last;
    logic                 w_final;
`ifdef MINMAX_SEQ_TIMEOUT_EN
    logic [7:0]           r_to_cnt;
    logic                 w_timeout;

    assign w_timeout = (r_to_cnt == 8'd0);
`endif

    // ceil(N/len) > MAX_INTERVALS is the same as len*MAX_INTERVALS < N, so no divider is needed.
    assign w_span    = 48'(r_len) * LP_MAX48;
    assign w_cfg_bad = (r_len == 16'd0) || (48'(r_len) > LP_N48) || (w_span < LP_N48);
    assign w_final   = (r_sample_cnt == LP_LAST_SMP);
    assign w_last    = (r_in_cnt == (r_len - 16'd1)) || w_final;

    assign error    = r_error;
    assign mem_addr = r_sample_cnt;
    assign eng_data = r_eng_data;
    assign res_addr = r_int_cnt;
    assign res_max  = r_res_max;
    assign res_min  = r_res_min;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd      = 1'b0;
        eng_valid   = 1'b0;
        eng_first   = 1'b0;
        eng_last    = 1'b0;
        res_we      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy        = 1'b1;
                w_state_nxt = w_cfg_bad ? FIN : FETCH;
            end
            FETCH: begin
                busy        = 1'b1;
                mem_rd      = 1'b1;
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy        = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                eng_valid = 1'b1;
                eng_first = (r_in_cnt == 16'd0);
                eng_last  = w_last;
                if (eng_ready) begin
                    w_state_nxt = w_last ? WAIT_RES : FETCH;
                end
            end
            WAIT_RES: begin
                busy = 1'b1;
                if (eng_res_valid) begin
                    w_state_nxt = WRITE;
                end
`ifdef MINMAX_SEQ_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = FIN;
                end
`endif
            end
            WRITE: begin
                busy        = 1'b1;
                res_we      = 1'b1;
                w_state_nxt = w_final ? FIN : FETCH;
            end
            FIN: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len        <= 16'd0;
            r_in_cnt     <= 16'd0;
            r_sample_cnt <= '0;
            r_int_cnt    <= '0;
            r_error      <= 1'b0;
            r_eng_data   <= '0;
            r_res_max    <= '0;
            r_res_min    <= '0;
`ifdef MINMAX_SEQ_TIMEOUT_EN
            r_to_cnt     <= 8'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len        <= interval_len;
                        r_error      <= 1'b0;
                        r_in_cnt     <= 16'd0;
                        r_sample_cnt <= '0;
                        r_int_cnt    <= '0;
                    end
                end
                CHECK: begin
                    if (w_cfg_bad) begin
                        r_error <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_eng_data <= mem_rdata;
                end
                SEND: begin
                    if (eng_ready) begin
                        if (!w_last) begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                            r_in_cnt     <= r_in_cnt + 16'd1;
                        end
`ifdef MINMAX_SEQ_TIMEOUT_EN
                        else begin
                            r_to_cnt <= 8'hFF;
                        end
`endif
                    end
                end
                WAIT_RES: begin
                    if (eng_res_valid) begin
                        r_res_max <= eng_res_max;
                        r_res_min <= eng_res_min;
                    end
`ifdef MINMAX_SEQ_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt - 8'd1;
                    end
`endif
                end
                WRITE: begin
                    // The last interval ends on sample N-1; otherwise step into the next one.
                    if (!w_final) begin
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                        r_in_cnt     <= 16'd0;
                        r_int_cnt    <= r_int_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/minmax_interval_sequencer.md
MINMAX_INTERVAL_SEQUENCER -- requirements
Module: minmax_interval_sequencer

Interface
REQ-001 SHALL have parameter N, default 100: total samples per run.
REQ-002 SHALL have parameter MAX_INTERVALS, default 10: result-buffer depth.
REQ-003 SHALL have parameter AW, default 16: width of sample-memory and result addresses.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the port start, input, 1 bit: begins a run; sampled only in IDLE.
REQ-007 SHALL have the port interval_len, input, 16 bits: samples per interval; latched at start.
REQ-008 SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have the port done, output, 1 bit: one-cycle pulse at end of run.
REQ-010 SHALL have the port error, output, 1 bit: sticky flag; cleared by the next accepted start.
REQ-011 SHALL have the ports mem_rd (output, 1 bit) and mem_addr (output, AW bits): sample-memory read request.
REQ-012 SHALL have the port mem_rdata, input, signed 32 bits: read data, valid exactly 1 cycle after mem_rd.
REQ-013 SHALL have the ports eng_valid, eng_first and eng_last (outputs, 1 bit each) and eng_data (output, signed 32 bits): sample stream to the min/max engine.
REQ-014 SHALL have the port eng_ready, input, 1 bit: engine accepts the presented sample.
REQ-015 SHALL have the ports eng_res_valid (input, 1 bit) and eng_res_max, eng_res_min (inputs, signed 32 bits each): per-interval engine result.
REQ-016 SHALL have the ports res_we (output, 1 bit), res_addr (output, AW bits) and res_max, res_min (outputs, signed 32 bits each): result-buffer write.

Function
REQ-017 SHALL implement states IDLE, CHECK, FETCH, CAPTURE, SEND, WAIT_RES, WRITE and FIN.
REQ-018 IDLE with start=1 SHALL latch interval_len, clear error and the sample/interval counters, and go to CHECK.
REQ-019 CHECK SHALL compute NI=ceil(N/len); if len==0, len>N or NI>MAX_INTERVALS it SHALL set error and go to FIN without any mem_rd, else go to FETCH.
REQ-020 FETCH SHALL assert mem_rd for 1 cycle with mem_addr equal to the sample counter.
REQ-021 CAPTURE SHALL register mem_rdata into eng_data.
REQ-022 SEND SHALL hold eng_valid, eng_data, eng_first and eng_last stable until eng_ready=1, and a transfer SHALL occur on eng_valid&eng_ready.
REQ-023 eng_first SHALL be high on the first sample of each interval.
REQ-024 eng_last SHALL be high when the in-interval count equals len-1 or on sample N-1; the final interval is therefore short when N mod len is nonzero.
REQ-025 After a transfer in SEND, the block SHALL go to WAIT_RES if eng_last was high, else to FETCH with the sample counter incremented.
REQ-026 WAIT_RES SHALL capture eng_res_max/eng_res_min on eng_res_valid and go to WRITE; eng_res_valid in any other state SHALL be ignored.
REQ-027 WRITE SHALL pulse res_we for 1 cycle with res_addr equal to the interval index, then go to FETCH if intervals remain, else to FIN.
REQ-028 FIN SHALL pulse done for 1 cycle and return to IDLE; start while busy SHALL be ignored.
REQ-029 Throughput SHALL be 3 cycles per sample with eng_ready held high.

Reset
REQ-030 While reset=0, the block SHALL be in IDLE with all outputs 0 and all counters and registers 0, taking effect immediately without waiting for a clock edge.
REQ-031 Reset asserted mid-run SHALL abort the run: no further mem_rd or res_we, and no done pulse.

Configuration
REQ-032 With macro MINMAX_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL run in WAIT_RES; after 255 cycles without eng_res_valid the block SHALL set error, skip WRITE, and go to FIN.
REQ-033 Without MINMAX_SEQ_TIMEOUT_EN, WAIT_RES SHALL wait indefinitely.

Verification
REQ-034 Bench SHALL cover: N=100, len=10, reference engine model, samples 0..9 = {196608,458752,0,...} -> 10 res_we pulses; addr 0 max 458752 min 0; addr 9 max -1245184 min -1769472; done once.
REQ-035 Bench SHALL cover: len=30 -> 4 writes; eng_last asserted on addresses 29, 59, 89 and 99.
REQ-036 Bench SHALL cover: len=0 and len=5 (NI=20>10) -> error=1, done pulses 2 cycles after start, zero mem_rd.
REQ-037 Bench SHALL cover: eng_ready low for 5 cycles in SEND -> eng_data and eng_valid held stable; sample order unchanged.
REQ-038 Bench SHALL cover: reset pulled low after sample 42 -> all outputs 0 at once; a new start then completes the full run correctly.
REQ-039 Bench SHALL cover, with MINMAX_SEQ_TIMEOUT_EN defined: engine never returns a result -> error=1 and done 256 cycles after entering WAIT_RES, with no res_we.
